// File: rtl/capture_word_packer.sv
// Byte-to-word packer: little-endian lanes, flush/timeout end markers, xorshift test pattern.
// Latency: word appears 1 cycle after its last byte or flush; backpressure holds the output and drops in_ack_o once BYTES-1 bytes wait.
module capture_word_packer #(
    parameter int          BYTES   = 2,
    parameter int          TIMEOUT = 1024,
    parameter logic [7:0]  PAD     = 8'h00,
    parameter logic [15:0] SEED    = 16'h6c51
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic [7:0]           in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ack_o,
    input  logic                 flush_i,
    input  logic                 test_i,
    output logic [8*BYTES-1:0]   out_data_o,
    output logic [3:0]           out_bytes_o,
    output logic                 out_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam int              TW      = $clog2(TIMEOUT);
    localparam logic [3:0]      FULL    = 4'(BYTES);
    localparam logic [3:0]      FULL_M1 = 4'(BYTES - 1);
    localparam logic [TW-1:0]   TMO_M1  = TW'(TIMEOUT - 1);

    function automatic logic [15:0] xorshift16(input logic [15:0] s);
        logic [15:0] t1;
        logic [15:0] t2;
        t1 = s ^ (s << 7);
        t2 = t1 ^ (t1 >> 9);
        return t2 ^ (t2 << 8);
    endfunction

    logic [BYTES-1:0][7:0] lane_q;
    logic [3:0]            fill_q, fill_d, fill_nxt;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  pend_q, pend_d;
    logic                  test_q;
    logic [15:0]           rng_q, rng_d;

    logic                  ov_d, ol_d;
    logic [8*BYTES-1:0]    od_d;
    logic [3:0]            ob_d;

    logic                  slot_free, word_done, timeout_hit, flush_req, emit;
    logic [8*BYTES-1:0]    word_c, rep_c;

    assign slot_free   = !out_valid_o || out_ready_i;
    assign in_ack_o    = in_valid_i && !test_i && !clear_i && ((fill_q < FULL_M1) || slot_free);
    assign fill_nxt    = fill_q + {3'b000, in_ack_o};
    assign word_done   = in_ack_o && (fill_q == FULL_M1);
    assign timeout_hit = (fill_q != 4'd0) && (timer_q == TMO_M1);
    assign flush_req   = pend_q || flush_i || timeout_hit;
    // The cycle leaving test mode is reserved for dropping out_valid_o.
    assign emit        = slot_free && !test_q && (word_done || flush_req);

    // Word as it would look with this cycle's byte merged in.
    always_comb begin
        word_c = '0;
        rep_c  = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (4'(k) < fill_q)
                word_c[8*k +: 8] = lane_q[k];
            else if (4'(k) == fill_q && in_ack_o)
                word_c[8*k +: 8] = in_data_i;
            else
                word_c[8*k +: 8] = PAD;
            rep_c[8*k +: 8] = (k % 2 == 1) ? rng_q[15:8] : rng_q[7:0];
        end
    end

    always_comb begin
        fill_d  = fill_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        rng_d   = rng_q;
        ov_d    = out_valid_o && !out_ready_i;
        od_d    = out_data_o;
        ob_d    = out_bytes_o;
        ol_d    = out_last_o;
        if (test_i) begin
            fill_d  = 4'd0;
            timer_d = '0;
            pend_d  = 1'b0;
            if (slot_free) begin
                ov_d  = 1'b1;
                od_d  = rep_c;
                ob_d  = FULL;
                ol_d  = 1'b0;
                rng_d = xorshift16(rng_q);
            end
        end else begin
            rng_d  = SEED;
            fill_d = fill_nxt;
            if (test_q)
                ov_d = 1'b0;
            if (emit) begin
                ov_d   = 1'b1;
                od_d   = word_c;
                ob_d   = fill_nxt;
                ol_d   = flush_req;
                fill_d = 4'd0;
            end
            pend_d = emit ? 1'b0 : (pend_q || flush_i);
            // Timer saturates so a stalled timeout keeps retrying.
            if (in_ack_o || fill_d == 4'd0)
                timer_d = '0;
            else if (timer_q != TMO_M1)
                timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lane_q      <= '0;
            fill_q      <= 4'd0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            test_q      <= 1'b0;
            rng_q       <= SEED;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_bytes_o <= 4'd0;
            out_last_o  <= 1'b0;
        end else if (clear_i) begin
            lane_q      <= '0;
            fill_q      <= 4'd0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            test_q      <= 1'b0;
            rng_q       <= SEED;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_bytes_o <= 4'd0;
            out_last_o  <= 1'b0;
        end else begin
            for (int k = 0; k < BYTES; k++)
                if (in_ack_o && fill_q == 4'(k))
                    lane_q[k] <= in_data_i;
            fill_q      <= fill_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            test_q      <= test_i;
            rng_q       <= rng_d;
            out_valid_o <= ov_d;
            out_data_o  <= od_d;
            out_bytes_o <= ob_d;
            out_last_o  <= ol_d;
        end
    end

endmodule
